retire_checker: RTL and testbench

Parametrised, buffered retirement checker for the RV32I core bench. It accepts two independent streams of architectural commit events: one from the DUT datapath, one from the `rv32i` reference model. Each stream is queued in its own FIFO, so the DUT pipeline latency may differ from the model's. Queue heads are compared in order and the block keeps match/mismatch statistics, a sticky first-error capture and a stall watchdog. It replaces per-cycle, per-opcode checking with one uniform event check covering register writes and data-memory stores.

---
 rtl/retire_checker_pkg.sv | 28 ++
 rtl/retire_checker_fifo.sv | 53 +++++
 rtl/retire_checker.sv | 193 +++++++++++++++++++
 tb/tb_retire_checker.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_checker_pkg.sv
// Shared types for retire_checker: commit event layout, kind encoding and checker FSM states.
package retire_checker_pkg;

  typedef enum logic [1:0] {
    KIND_REG   = 2'd0,
    KIND_STORE = 2'd1
  } commit_kind_e;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_IDX_W = 32;

  typedef struct packed {
    logic [1:0]           kind;
    logic [DEF_XLEN-1:0]  pc;
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_XLEN-1:0]  data;
  } commit_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } chk_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/retire_checker_fifo.sv
// chk_fifo: synchronous FIFO of commit entries with flush; pointers carry one extra wrap bit.
module chk_fifo
  import retire_checker_pkg::*;
#(
  parameter type T     = commit_t,
  parameter int  DEPTH = 8
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_flush,
  input  T     i_data,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;

  // Pointer update; flush wins over any same-cycle push or pop.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wptr <= {PW{1'b0}};
      r_rptr <= {PW{1'b0}};
    end else if (i_flush) begin
      r_wptr <= {PW{1'b0}};
      r_rptr <= {PW{1'b0}};
    end else begin
      if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/retire_checker.sv
// retire_checker: buffers DUT and reference commit streams and compares queue heads in order.
// Optional stall watchdog is built when RETIRE_CHECKER_TIMEOUT_EN is defined.
module retire_checker
  import retire_checker_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IDX_W       = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT     = 64,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_dut_valid,
  output logic             o_dut_ready,
  input  logic [1:0]       i_dut_kind,
  input  logic [XLEN-1:0]  i_dut_pc,
  input  logic [IDX_W-1:0] i_dut_idx,
  input  logic [XLEN-1:0]  i_dut_data,
  input  logic             i_ref_valid,
  output logic             o_ref_ready,
  input  logic [1:0]       i_ref_kind,
  input  logic [XLEN-1:0]  i_ref_pc,
  input  logic [IDX_W-1:0] i_ref_idx,
  input  logic [XLEN-1:0]  i_ref_data,
  input  logic             i_flush,
  output logic [31:0]      o_match_cnt,
  output logic [31:0]      o_mismatch_cnt,
  output logic             o_err_valid,
  output logic [XLEN-1:0]  o_err_pc,
  output logic [XLEN-1:0]  o_err_dut_data,
  output logic [XLEN-1:0]  o_err_ref_data,
  output logic             o_timeout,
  output logic             o_halted,
  output logic             o_idle
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("retire_checker: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("retire_checker: TIMEOUT must be >= 1");
  end

  typedef struct packed {
    logic [1:0]       kind;
    logic [XLEN-1:0]  pc;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  data;
  } entry_t;

  chk_state_e      r_state;
  logic [31:0]     r_match_cnt;
  logic [31:0]     r_mismatch_cnt;
  logic            r_err_valid;
  logic [XLEN-1:0] r_err_pc;
  logic [XLEN-1:0] r_err_dut_data;
  logic [XLEN-1:0] r_err_ref_data;
  logic            r_halted;

  entry_t w_dut_in, w_ref_in, w_dut_head, w_ref_head;
  logic   w_dut_full, w_dut_empty, w_ref_full, w_ref_empty;
  logic   w_dut_push, w_ref_push, w_cmp, w_match;

  assign w_dut_in.kind = i_dut_kind;
  assign w_dut_in.pc   = i_dut_pc;
  assign w_dut_in.idx  = i_dut_idx;
  assign w_dut_in.data = i_dut_data;
  assign w_ref_in.kind = i_ref_kind;
  assign w_ref_in.pc   = i_ref_pc;
  assign w_ref_in.idx  = i_ref_idx;
  assign w_ref_in.data = i_ref_data;

  assign o_dut_ready = !w_dut_full && (r_state == RUN);
  assign o_ref_ready = !w_ref_full && (r_state == RUN);

  // Writes to x0 complete the handshake but carry no architectural effect, so they are not queued.
  assign w_dut_push = i_dut_valid && o_dut_ready &&
                      !((i_dut_kind == KIND_REG) && (i_dut_idx == {IDX_W{1'b0}}));
  assign w_ref_push = i_ref_valid && o_ref_ready &&
                      !((i_ref_kind == KIND_REG) && (i_ref_idx == {IDX_W{1'b0}}));

  assign w_cmp   = !w_dut_empty && !w_ref_empty && (r_state == RUN) && !i_flush;
  assign w_match = (w_dut_head === w_ref_head);

  chk_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_dut_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (w_dut_push),
    .i_pop   (w_cmp),
    .i_flush (i_flush),
    .i_data  (w_dut_in),
    .o_head  (w_dut_head),
    .o_full  (w_dut_full),
    .o_empty (w_dut_empty)
  );

  chk_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_ref_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (w_ref_push),
    .i_pop   (w_cmp),
    .i_flush (i_flush),
    .i_data  (w_ref_in),
    .o_head  (w_ref_head),
    .o_full  (w_ref_full),
    .o_empty (w_ref_empty)
  );

  // Checker FSM with statistics and sticky first-mismatch capture.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state        <= RUN;
      r_halted       <= 1'b0;
      r_match_cnt    <= 32'd0;
      r_mismatch_cnt <= 32'd0;
      r_err_valid    <= 1'b0;
      r_err_pc       <= {XLEN{1'b0}};
      r_err_dut_data <= {XLEN{1'b0}};
      r_err_ref_data <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        RUN: begin
          if (w_cmp) begin
            if (w_match) begin
              r_match_cnt <= sat_inc(r_match_cnt);
            end else begin
              r_mismatch_cnt <= sat_inc(r_mismatch_cnt);
              if (!r_err_valid) begin
                r_err_valid    <= 1'b1;
                r_err_pc       <= w_dut_head.pc;
                r_err_dut_data <= w_dut_head.data;
                r_err_ref_data <= w_ref_head.data;
              end
              if (STOP_ON_ERR) begin
                r_state  <= HALT;
                r_halted <= 1'b1;
              end
            end
          end
        end
        HALT: begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef RETIRE_CHECKER_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        r_timeout;
  logic        w_wd_clear, w_wd_inc;

  assign w_wd_clear = i_flush || w_cmp || (w_dut_empty && w_ref_empty);
  assign w_wd_inc   = (w_dut_empty != w_ref_empty) && (r_wd_cnt < 32'(TIMEOUT));

  // Stall watchdog: counts cycles where only one side has pending work.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wd_cnt  <= 32'd0;
      r_timeout <= 1'b0;
    end else begin
      if (w_wd_clear) begin
        r_wd_cnt <= 32'd0;
      end else if (w_wd_inc) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
        if (r_wd_cnt == 32'(TIMEOUT - 1)) r_timeout <= 1'b1;
      end else begin
        r_wd_cnt <= r_wd_cnt;
      end
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_match_cnt    = r_match_cnt;
  assign o_mismatch_cnt = r_mismatch_cnt;
  assign o_err_valid    = r_err_valid;
  assign o_err_pc       = r_err_pc;
  assign o_err_dut_data = r_err_dut_data;
  assign o_err_ref_data = r_err_ref_data;
  assign o_halted       = r_halted;
  assign o_idle         = w_dut_empty && w_ref_empty;

endmodule

// File: tb/tb_retire_checker.sv
// Scoreboard bench for retire_checker: reference model pairs accepted events, monitor checks compares.
module tb_retire_checker;
  import retire_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_dut_valid, i_ref_valid, i_flush;
  logic        o_dut_ready, o_ref_ready;
  logic [1:0]  i_dut_kind, i_ref_kind;
  logic [31:0] i_dut_pc, i_dut_idx, i_dut_data, i_ref_pc, i_ref_idx, i_ref_data;
  logic [31:0] o_match_cnt, o_mismatch_cnt, o_err_pc, o_err_dut_data, o_err_ref_data;
  logic        o_err_valid, o_timeout, o_halted, o_idle;

  always #5 clk = ~clk;

  retire_checker #(.XLEN(32), .IDX_W(32), .DEPTH(8), .TIMEOUT(4), .STOP_ON_ERR(1'b1)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_dut_valid(i_dut_valid), .o_dut_ready(o_dut_ready), .i_dut_kind(i_dut_kind),
    .i_dut_pc(i_dut_pc), .i_dut_idx(i_dut_idx), .i_dut_data(i_dut_data),
    .i_ref_valid(i_ref_valid), .o_ref_ready(o_ref_ready), .i_ref_kind(i_ref_kind),
    .i_ref_pc(i_ref_pc), .i_ref_idx(i_ref_idx), .i_ref_data(i_ref_data),
    .i_flush(i_flush), .o_match_cnt(o_match_cnt), .o_mismatch_cnt(o_mismatch_cnt),
    .o_err_valid(o_err_valid), .o_err_pc(o_err_pc), .o_err_dut_data(o_err_dut_data),
    .o_err_ref_data(o_err_ref_data), .o_timeout(o_timeout), .o_halted(o_halted), .o_idle(o_idle)
  );

  typedef struct {
    bit          match;
    bit          first;
    logic [31:0] pc;
    logic [31:0] dd;
    logic [31:0] rd;
  } exp_t;

  int      n_checks = 0;
  int      n_err    = 0;
  exp_t    exp_q[$];
  commit_t mq_d[$], mq_r[$];
  int      m_match, m_mm;
  bit      m_halt, m_mm_seen;
  logic    last_dut_rdy, last_ref_rdy, da, ra;
  commit_t z = '0;

`ifdef RETIRE_CHECKER_TIMEOUT_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic commit_t mk(input logic [1:0] k, input logic [31:0] pc,
                                 input logic [31:0] idx, input logic [31:0] data);
    commit_t c;
    c.kind = k; c.pc = pc; c.idx = idx; c.data = data;
    return c;
  endfunction

  function automatic bit is_x0(input commit_t c);
    return (c.kind == 2'd0) && (c.idx == 32'd0);
  endfunction

  // Reference model: accepted events are paired in arrival order; first mismatch halts pairing.
  task automatic pair_model();
    while (mq_d.size() > 0 && mq_r.size() > 0 && !m_halt) begin
      commit_t a, b;
      exp_t    e;
      a = mq_d.pop_front();
      b = mq_r.pop_front();
      e.match = (a === b);
      e.first = !m_mm_seen;
      e.pc = a.pc; e.dd = a.data; e.rd = b.data;
      if (e.match) m_match++;
      else begin
        m_mm++;
        m_mm_seen = 1'b1;
        m_halt = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input logic dv, input commit_t de, input logic rv, input commit_t re,
                      input logic fl, output logic dacc, output logic racc);
    i_dut_valid = dv; i_dut_kind = de.kind; i_dut_pc = de.pc; i_dut_idx = de.idx; i_dut_data = de.data;
    i_ref_valid = rv; i_ref_kind = re.kind; i_ref_pc = re.pc; i_ref_idx = re.idx; i_ref_data = re.data;
    i_flush = fl;
    last_dut_rdy = o_dut_ready;
    last_ref_rdy = o_ref_ready;
    dacc = dv && o_dut_ready;
    racc = rv && o_ref_ready;
    @(posedge clk);
    if (fl) begin
      mq_d.delete();
      mq_r.delete();
    end else begin
      if (dacc && !is_x0(de)) mq_d.push_back(de);
      if (racc && !is_x0(re)) mq_r.push_back(re);
      pair_model();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, z, 1'b0, z, 1'b0, da, ra);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    i_dut_valid = 1'b0; i_ref_valid = 1'b0; i_flush = 1'b0;
    mq_d.delete(); mq_r.delete(); exp_q.delete();
    m_match = 0; m_mm = 0; m_halt = 1'b0; m_mm_seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle_step();
    idle_step();
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic final_check(input string tag);
    chk({tag, "_match"}, 64'(o_match_cnt), 64'(m_match));
    chk({tag, "_mismatch"}, 64'(o_mismatch_cnt), 64'(m_mm));
    chk({tag, "_halted"}, 64'(o_halted), 64'(m_halt));
    chk({tag, "_idle"}, 64'(o_idle), 64'(mq_d.size() == 0 && mq_r.size() == 0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_match"}, 64'(o_match_cnt), 64'd0);
    chk({tag, "_mismatch"}, 64'(o_mismatch_cnt), 64'd0);
    chk({tag, "_err"}, {o_err_valid, o_err_pc, o_err_dut_data[0]}, 64'd0);
    chk({tag, "_errdata"}, {o_err_dut_data, o_err_ref_data}, 64'd0);
    chk({tag, "_flags"}, {o_timeout, o_halted, o_idle, o_dut_ready, o_ref_ready}, 64'b00111);
  endtask

  // Monitor: every change in the statistics must correspond to the next expected compare.
  logic [31:0] pm, pmm;
  exp_t        me;
  initial begin
    pm = 32'd0; pmm = 32'd0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        pm = 32'd0; pmm = 32'd0;
      end else if (o_match_cnt != pm || o_mismatch_cnt != pmm) begin
        chk("cmp_delta", 64'(o_match_cnt - pm) + 64'(o_mismatch_cnt - pmm), 64'd1);
        if (exp_q.size() == 0) begin
          chk("cmp_unexpected", 64'(o_match_cnt), 64'(pm));
        end else begin
          me = exp_q.pop_front();
          chk("cmp_result", 64'(o_match_cnt != pm), 64'(me.match));
          if (!me.match && me.first) begin
            chk("err_valid", 64'(o_err_valid), 64'd1);
            chk("err_pc", 64'(o_err_pc), 64'(me.pc));
            chk("err_dut_data", 64'(o_err_dut_data), 64'(me.dd));
            chk("err_ref_data", 64'(o_err_ref_data), 64'(me.rd));
            chk("err_halted", 64'(o_halted), 64'd1);
          end
        end
        pm = o_match_cnt;
        pmm = o_mismatch_cnt;
      end
    end
  end

  task automatic rand_round(input string tag, input bit corrupt);
    commit_t rl[$], dl[$];
    commit_t e, c;
    int n, ci, di, ri;
    n  = 30;
    ci = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0)
        e = mk(2'($urandom_range(0, 3)), 32'(4 * i), 32'($urandom_range(1, 31)), $urandom);
      else
        e = mk(2'($urandom_range(0, 3)), 32'(4 * i), {1'b1, 31'($urandom)}, $urandom);
      c = e;
      if (corrupt && i == ci) begin
        case ($urandom_range(0, 3))
          0: c.kind = c.kind ^ 2'b10;
          1: c.pc = c.pc ^ (32'd1 << $urandom_range(2, 31));
          2: c.idx = c.idx ^ (32'd1 << $urandom_range(5, 30));
          default: c.data = c.data ^ (32'd1 << $urandom_range(0, 31));
        endcase
      end
      rl.push_back(e);
      dl.push_back(c);
      if ($urandom_range(0, 5) == 0) dl.push_back(mk(2'd0, 32'hF00, 32'd0, $urandom));
      if ($urandom_range(0, 7) == 0) rl.push_back(mk(2'd0, 32'hF04, 32'd0, $urandom));
    end
    di = 0; ri = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic dv, rv;
      if (di == dl.size() && ri == rl.size()) break;
      if (m_halt && o_halted) break;
      dv = (di < dl.size()) && ($urandom_range(0, 3) != 0);
      rv = (ri < rl.size()) && ($urandom_range(0, 3) != 0);
      step(dv, dv ? dl[di] : z, rv, rv ? rl[ri] : z, 1'b0, da, ra);
      if (da) di++;
      if (ra) ri++;
    end
    drain(tag);
    final_check(tag);
  endtask

  commit_t ev[9];
  commit_t evd;

  initial begin
    rstn = 1'b0;
    i_dut_valid = 1'b0; i_ref_valid = 1'b0; i_flush = 1'b0;
    i_dut_kind = 2'd0; i_dut_pc = 32'd0; i_dut_idx = 32'd0; i_dut_data = 32'd0;
    i_ref_kind = 2'd0; i_ref_pc = 32'd0; i_ref_idx = 32'd0; i_ref_data = 32'd0;
    @(negedge clk);
    reset_dut();
    check_reset_vals("reset");

    // Equal streams, DUT three cycles behind the reference.
    for (int i = 0; i < 5; i++) ev[i] = mk(2'd0, 32'(4 * i), 32'(i + 1), 32'(10 * (i + 1)));
    for (int t = 0; t < 8; t++)
      step(t >= 3, (t >= 3) ? ev[t - 3] : z, t < 5, (t < 5) ? ev[t] : z, 1'b0, da, ra);
    drain("equal");
    chk("equal_match", 64'(o_match_cnt), 64'd5);
    chk("equal_mismatch", 64'(o_mismatch_cnt), 64'd0);
    chk("equal_idle", 64'(o_idle), 64'd1);

    // Single mismatch on the third event.
    reset_dut();
    for (int t = 0; t < 5; t++) begin
      evd = ev[t];
      if (t == 2) begin
        ev[t].data = 32'h2B;
        evd.data = 32'h2A;
      end
      step(1'b1, evd, 1'b1, ev[t], 1'b0, da, ra);
    end
    drain("mism");
    chk("mism_err_valid", 64'(o_err_valid), 64'd1);
    chk("mism_err_pc", 64'(o_err_pc), 64'h8);
    chk("mism_err_data", {o_err_dut_data, o_err_ref_data}, {32'h2A, 32'h2B});
    chk("mism_halted", 64'(o_halted), 64'd1);
    chk("mism_readies", {o_dut_ready, o_ref_ready}, 64'd0);
    chk("mism_match", 64'(o_match_cnt), 64'd2);
    chk("mism_mismatch", 64'(o_mismatch_cnt), 64'd1);

    // Full and backpressure on the reference side.
    reset_dut();
    for (int i = 0; i < 9; i++) ev[i] = mk(2'd1, 32'(4 * i), {1'b1, 31'(i)}, $urandom);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, z, 1'b1, ev[i], 1'b0, da, ra);
      chk($sformatf("full_rdy_%0d", i), 64'(last_ref_rdy), (i < 8) ? 64'd1 : 64'd0);
    end
    begin
      bit sent9;
      sent9 = 1'b0;
      for (int d = 0; d < 9; d++) begin
        step(1'b1, ev[d], !sent9, ev[8], 1'b0, da, ra);
        if (ra) sent9 = 1'b1;
        if (d == 1) chk("full_rdy_before_pop", 64'(last_ref_rdy), 64'd0);
        if (d == 2) chk("full_rdy_after_pop", 64'(last_ref_rdy), 64'd1);
      end
    end
    drain("full");
    final_check("full");
    chk("full_match", 64'(o_match_cnt), 64'd9);

    // x0 writes complete the handshake but are never queued.
    reset_dut();
    step(1'b1, mk(2'd0, 32'h100, 32'd0, 32'h55), 1'b0, z, 1'b0, da, ra);
    chk("x0_accepted", 64'(last_dut_rdy), 64'd1);
    chk("x0_idle", 64'(o_idle), 64'd1);
    idle_step();
    chk("x0_counts", {o_match_cnt, o_mismatch_cnt}, 64'd0);
    chk("x0_idle_later", 64'(o_idle), 64'd1);

    // Watchdog with one lonely reference entry, then flush with a dropped push.
    reset_dut();
    step(1'b0, z, 1'b1, ev[0], 1'b0, da, ra);
    for (int i = 0; i < 3; i++) idle_step();
    chk("wd_before", 64'(o_timeout), 64'd0);
    idle_step();
    chk("wd_fire", 64'(o_timeout), 64'(WD_ON));
    step(1'b1, ev[1], 1'b0, z, 1'b1, da, ra);
    chk("flush_rdy", 64'(last_dut_rdy), 64'd1);
    chk("flush_idle", 64'(o_idle), 64'd1);
    chk("flush_wd_sticky", 64'(o_timeout), 64'(WD_ON));
    idle_step();
    chk("flush_idle_later", 64'(o_idle), 64'd1);
    mq_d.delete(); mq_r.delete();
    final_check("flush");

    // Randomized rounds against the reference model.
    for (int r = 0; r < 6; r++) begin
      reset_dut();
      rand_round($sformatf("rand%0d", r), r >= 3);
    end
    reset_dut();
    rand_round("rand_clean", 1'b0);

    // Reset while entries are queued.
    for (int i = 0; i < 4; i++) step(1'b0, z, 1'b1, mk(2'd1, 32'(i), 32'hFFFF_0000, 32'(i)), 1'b0, da, ra);
    chk("midrst_busy", 64'(o_idle), 64'd0);
    reset_dut();
    check_reset_vals("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
